// File: rtl/plab3_mem_blocking_l2_cache_nway_pkg.sv
// rtl/plab3_mem_blocking_l2_cache_nway_pkg.sv - shared types, message codes and widths for the N-way L2
package plab3_mem_blocking_l2_cache_nway_pkg;

  localparam int MEM_TYPE_NBITS = 3;
  localparam int MEM_TEST_NBITS = 2;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG_CHECK,
    S_RESP,
    S_EVICT_REQ,
    S_EVICT_WAIT,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_UPDATE
  } state_t;

  // Request layout (MSB..LSB): type, opaque, addr, len, data
  function automatic int req_msg_nbits(input int o, input int a, input int d);
    return MEM_TYPE_NBITS + o + a + $clog2(d / 8) + d;
  endfunction

  // Response layout (MSB..LSB): type, opaque, test, len, data
  function automatic int resp_msg_nbits(input int o, input int d);
    return MEM_TYPE_NBITS + o + MEM_TEST_NBITS + $clog2(d / 8) + d;
  endfunction

endpackage

// File: rtl/plab3_mem_blocking_l2_cache_nway_if.sv
// rtl/plab3_mem_blocking_l2_cache_nway_if.sv - L1-side and memory-side handshake bundle of the L2
interface plab3_mem_blocking_l2_cache_nway_if #(
  parameter int O = 8,
  parameter int A = 32,
  parameter int D = 128
);
  import plab3_mem_blocking_l2_cache_nway_pkg::*;

  localparam int REQ_NBITS  = req_msg_nbits(O, A, D);
  localparam int RESP_NBITS = resp_msg_nbits(O, D);

  logic [REQ_NBITS-1:0]  cachereq_msg;
  logic                  cachereq_val;
  logic                  cachereq_rdy;
  logic                  insecure;
  logic [RESP_NBITS-1:0] cacheresp_msg;
  logic                  cacheresp_val;
  logic                  cacheresp_rdy;
  logic [REQ_NBITS-1:0]  memreq_msg;
  logic                  memreq_val;
  logic                  memreq_rdy;
  logic [RESP_NBITS-1:0] memresp_msg;
  logic                  memresp_val;
  logic                  memresp_rdy;

  // L1 + memory environment side
  modport master (
    output cachereq_msg, cachereq_val, insecure, cacheresp_rdy, memreq_rdy, memresp_msg, memresp_val,
    input  cachereq_rdy, cacheresp_msg, cacheresp_val, memreq_msg, memreq_val, memresp_rdy
  );

  // Cache side
  modport slave (
    input  cachereq_msg, cachereq_val, insecure, cacheresp_rdy, memreq_rdy, memresp_msg, memresp_val,
    output cachereq_rdy, cacheresp_msg, cacheresp_val, memreq_msg, memreq_val, memresp_rdy
  );

endinterface

// File: rtl/plab3_mem_l2_victim_sel.sv
// rtl/plab3_mem_l2_victim_sel.sv - victim way choice: lowest invalid way, else round-robin pointer
module plab3_mem_l2_victim_sel #(
  parameter int p_num_ways   = 4,
  parameter int p_way_nbits  = 2
) (
  input  logic [p_num_ways-1:0]  valid_i,
  input  logic [p_way_nbits-1:0] rr_ptr_i,
  output logic [p_way_nbits-1:0] victim_o,
  output logic                   any_invalid_o,
  output logic [p_way_nbits-1:0] rr_next_o
);

  // Scan from the top so the lowest-index invalid way is the one that sticks
  always_comb begin
    victim_o      = rr_ptr_i;
    any_invalid_o = 1'b0;
    for (int w = p_num_ways - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o      = p_way_nbits'(w);
        any_invalid_o = 1'b1;
      end
    end
    rr_next_o = (rr_ptr_i == p_way_nbits'(p_num_ways - 1)) ? '0 : rr_ptr_i + p_way_nbits'(1);
  end

endmodule

// File: rtl/plab3_mem_blocking_l2_cache_nway.sv
// rtl/plab3_mem_blocking_l2_cache_nway.sv - blocking N-way write-back write-allocate L2 bank with per-line security bit
module plab3_mem_blocking_l2_cache_nway
  import plab3_mem_blocking_l2_cache_nway_pkg::*;
#(
  parameter int p_mem_nbytes   = 256,
  parameter int p_num_ways     = 4,
  parameter int p_num_banks    = 1,
  parameter int p_opaque_nbits = 8,
  parameter int abw            = 32,
  parameter int clw            = 128
) (
  input logic clk,
  input logic reset,
  plab3_mem_blocking_l2_cache_nway_if.slave bus
);

  localparam int OFFW    = $clog2(clw / 8);
  localparam int NSETS   = p_mem_nbytes / (clw / 8 * p_num_ways);
  localparam int IDXW    = $clog2(NSETS);
  localparam int BANKW   = $clog2(p_num_banks);
  localparam int IDX_LSB = OFFW + BANKW;
  localparam int TAGW    = abw - IDX_LSB - IDXW;
  localparam int WAYW    = (p_num_ways > 1) ? $clog2(p_num_ways) : 1;
  localparam int O       = p_opaque_nbits;
  localparam int RESP_NBITS = resp_msg_nbits(O, clw);
  localparam int A_LSB   = clw + OFFW;
  localparam int O_LSB   = A_LSB + abw;
  localparam int T_LSB   = O_LSB + O;

  state_t            state_q;
  logic              cachereq_rdy_q, cacheresp_val_q, memreq_val_q, memresp_rdy_q;
  logic [2:0]        req_type_q;
  logic [O-1:0]      req_opq_q;
  logic [abw-1:0]    req_addr_q;
  logic [clw-1:0]    req_data_q;
  logic              req_insecure_q;
  logic [clw-1:0]    resp_data_q;
  logic [2:0]        memreq_type_q;
  logic [abw-1:0]    memreq_addr_q;
  logic [clw-1:0]    memreq_data_q;
  logic [clw-1:0]    refill_q;
  logic [WAYW-1:0]   victim_q;

  logic              valid_q [p_num_ways][NSETS];
  logic              dirty_q [p_num_ways][NSETS];
  logic              sec_q   [p_num_ways][NSETS];
  logic [TAGW-1:0]   tag_q   [p_num_ways][NSETS];
  logic [clw-1:0]    data_q  [p_num_ways][NSETS];
  logic [WAYW-1:0]   rr_q    [NSETS];

  logic [IDXW-1:0]       idx;
  logic [TAGW-1:0]       req_tag;
  logic [p_num_ways-1:0] set_valid;
  logic                  hit, denied, is_read, is_wr;
  logic [WAYW-1:0]       hit_way, victim_way, rr_next;
  logic                  any_invalid;
  logic [abw-1:0]        line_addr, evict_addr;
  logic                  data_we;
  logic [WAYW-1:0]       data_way;
  logic [clw-1:0]        data_wdata;
  logic                  unused_bits;

  assign idx        = req_addr_q[IDX_LSB +: IDXW];
  assign req_tag    = req_addr_q[abw-1 -: TAGW];
  assign is_read    = (req_type_q == MEM_READ);
  assign is_wr      = (req_type_q == MEM_WRITE) || (req_type_q == MEM_INIT);
  assign line_addr  = {req_addr_q[abw-1:OFFW], {OFFW{1'b0}}};
  assign evict_addr = {tag_q[victim_way][idx], req_addr_q[IDX_LSB+IDXW-1:OFFW], {OFFW{1'b0}}};
  assign unused_bits = ^{bus.cachereq_msg[clw +: OFFW], bus.memresp_msg[RESP_NBITS-1:clw]};

  // Tag lookup across all ways of the addressed set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int w = 0; w < p_num_ways; w++) begin
      set_valid[w] = valid_q[w][idx];
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
    denied = hit && sec_q[hit_way][idx] && req_insecure_q;
  end

  plab3_mem_l2_victim_sel #(
    .p_num_ways  (p_num_ways),
    .p_way_nbits (WAYW)
  ) u_victim_sel (
    .valid_i       (set_valid),
    .rr_ptr_i      (rr_q[idx]),
    .victim_o      (victim_way),
    .any_invalid_o (any_invalid),
    .rr_next_o     (rr_next)
  );

  // Line data write port: write hits in TAG_CHECK, fills/allocations in UPDATE
  always_comb begin
    data_we    = 1'b0;
    data_way   = victim_q;
    data_wdata = req_data_q;
    if (state_q == S_TAG_CHECK && is_wr && hit && !denied) begin
      data_we  = 1'b1;
      data_way = hit_way;
    end else if (state_q == S_UPDATE) begin
      data_we    = 1'b1;
      data_wdata = is_read ? refill_q : req_data_q;
    end
  end

  // Line data storage carries no reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_way][idx] <= data_wdata;
  end

  // Controller: state, registered handshake outputs and line metadata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cachereq_rdy_q  <= 1'b0;
      cacheresp_val_q <= 1'b0;
      memreq_val_q    <= 1'b0;
      memresp_rdy_q   <= 1'b0;
      req_type_q      <= '0;
      req_opq_q       <= '0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_insecure_q  <= 1'b0;
      resp_data_q     <= '0;
      memreq_type_q   <= '0;
      memreq_addr_q   <= '0;
      memreq_data_q   <= '0;
      refill_q        <= '0;
      victim_q        <= '0;
      for (int s = 0; s < NSETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < p_num_ways; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          sec_q[w][s]   <= 1'b0;
          tag_q[w][s]   <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cachereq_rdy_q && bus.cachereq_val) begin
            req_type_q     <= bus.cachereq_msg[T_LSB +: 3];
            req_opq_q      <= bus.cachereq_msg[O_LSB +: O];
            req_addr_q     <= bus.cachereq_msg[A_LSB +: abw];
            req_data_q     <= bus.cachereq_msg[clw-1:0];
            req_insecure_q <= bus.insecure;
            cachereq_rdy_q <= 1'b0;
            state_q        <= S_TAG_CHECK;
          end else begin
            cachereq_rdy_q <= 1'b1;
          end
        end
        S_TAG_CHECK: begin
          if (!(is_read || is_wr) || denied) begin
            resp_data_q     <= '0;
            cacheresp_val_q <= 1'b1;
            state_q         <= S_RESP;
          end else if (hit) begin
            if (is_read) begin
              resp_data_q <= data_q[hit_way][idx];
            end else begin
              resp_data_q            <= '0;
              dirty_q[hit_way][idx]  <= 1'b1;
              sec_q[hit_way][idx]    <= ~req_insecure_q;
            end
            cacheresp_val_q <= 1'b1;
            state_q         <= S_RESP;
          end else begin
            victim_q <= victim_way;
            if (!any_invalid) rr_q[idx] <= rr_next;
            if (valid_q[victim_way][idx] && dirty_q[victim_way][idx]) begin
              memreq_type_q <= MEM_WRITE;
              memreq_addr_q <= evict_addr;
              memreq_data_q <= data_q[victim_way][idx];
              memreq_val_q  <= 1'b1;
              state_q       <= S_EVICT_REQ;
            end else if (is_read) begin
              memreq_type_q <= MEM_READ;
              memreq_addr_q <= line_addr;
              memreq_data_q <= '0;
              memreq_val_q  <= 1'b1;
              state_q       <= S_REFILL_REQ;
            end else begin
              state_q <= S_UPDATE;
            end
          end
        end
        S_EVICT_REQ: begin
          if (bus.memreq_rdy) begin
            memreq_val_q  <= 1'b0;
            memresp_rdy_q <= 1'b1;
            state_q       <= S_EVICT_WAIT;
          end
        end
        S_EVICT_WAIT: begin
          if (bus.memresp_val) begin
            memresp_rdy_q <= 1'b0;
            if (is_read) begin
              memreq_type_q <= MEM_READ;
              memreq_addr_q <= line_addr;
              memreq_data_q <= '0;
              memreq_val_q  <= 1'b1;
              state_q       <= S_REFILL_REQ;
            end else begin
              state_q <= S_UPDATE;
            end
          end
        end
        S_REFILL_REQ: begin
          if (bus.memreq_rdy) begin
            memreq_val_q  <= 1'b0;
            memresp_rdy_q <= 1'b1;
            state_q       <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (bus.memresp_val) begin
            refill_q      <= bus.memresp_msg[clw-1:0];
            memresp_rdy_q <= 1'b0;
            state_q       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[victim_q][idx] <= 1'b1;
          dirty_q[victim_q][idx] <= is_wr;
          sec_q[victim_q][idx]   <= ~req_insecure_q;
          tag_q[victim_q][idx]   <= req_tag;
          resp_data_q            <= is_read ? refill_q : '0;
          cacheresp_val_q        <= 1'b1;
          state_q                <= S_RESP;
        end
        S_RESP: begin
          if (bus.cacheresp_rdy) begin
            cacheresp_val_q <= 1'b0;
            cachereq_rdy_q  <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cachereq_rdy  = cachereq_rdy_q;
  assign bus.cacheresp_val = cacheresp_val_q;
  assign bus.memreq_val    = memreq_val_q;
  assign bus.memresp_rdy   = memresp_rdy_q;
  assign bus.cacheresp_msg = {req_type_q, req_opq_q, {MEM_TEST_NBITS{1'b0}}, {OFFW{1'b0}}, resp_data_q};
  assign bus.memreq_msg    = {memreq_type_q, {O{1'b0}}, memreq_addr_q, {OFFW{1'b0}}, memreq_data_q};

endmodule
